// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the iterative single-precision divider
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          MANT_W   = 24;
    localparam int          Q_W      = 25;

endpackage

// File: rtl/mantissa_divider.sv
// rtl/mantissa_divider.sv - radix-2 restoring mantissa iterator, one quotient bit per enabled step
module mantissa_divider
    import fp_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [Q_W-1:0]    quotient
);

    logic [Q_W-1:0]    rem;
    logic [MANT_W-1:0] div_q;
    logic [MANT_W-1:0] diff;
    logic              ge;

    // The remainder always stays below 2*divisor, so the low MANT_W bits of the
    // difference are exact whenever the subtraction is taken.
    assign ge   = rem >= {1'b0, div_q};
    assign diff = rem[MANT_W-1:0] - div_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            div_q    <= '0;
            quotient <= '0;
        end else if (en) begin
            if (load) begin
                rem      <= {1'b0, dividend};
                div_q    <= divisor;
                quotient <= '0;
            end else if (step) begin
                quotient <= {quotient[Q_W-2:0], ge};
                rem      <= ge ? {diff, 1'b0} : {rem[MANT_W-1:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/floating_divider_iterative.sv
// rtl/floating_divider_iterative.sv - sequential IEEE-754 single divider, truncating, denormals flushed
module floating_divider_iterative
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

    state_t state, next_state;

    logic [4:0]        count;
    logic              load, step, finish;
    logic              sign_q, special_q, special_exc_q;
    logic [31:0]       special_res_q;
    logic signed [9:0] exp_q, exp_adj;
    logic [Q_W-1:0]    quotient;

    logic [7:0]  a_exp, b_exp;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        in_sign, in_special, spec_exc;
    logic [31:0] spec_res;
    logic [9:0]  exp_calc;
    logic [22:0] mant;

    assign a_exp   = a[30:23];
    assign b_exp   = b[30:23];
    assign a_zero  = (a_exp == 8'h00);
    assign b_zero  = (b_exp == 8'h00);
    assign a_inf   = (a_exp == 8'hFF) && (a[22:0] == 23'h0);
    assign b_inf   = (b_exp == 8'hFF) && (b[22:0] == 23'h0);
    assign a_nan   = (a_exp == 8'hFF) && (a[22:0] != 23'h0);
    assign b_nan   = (b_exp == 8'hFF) && (b[22:0] != 23'h0);
    assign in_sign = a[31] ^ b[31];
    assign in_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign exp_calc   = {2'b00, a_exp} - {2'b00, b_exp} + 10'(EXP_BIAS);

    // inf/0 counts as inf/finite: signed infinity without an exception.
    always_comb begin
        spec_res = {in_sign, 31'h0};
        spec_exc = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_exc = 1'b1;
        end else if (a_inf) begin
            spec_res = {in_sign, 8'hFF, 23'h0};
        end else if (b_zero) begin
            spec_res = {in_sign, 8'hFF, 23'h0};
            spec_exc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = in_special ? FIN : DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (count == 5'(Q_W - 1)) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            sign_q        <= 1'b0;
            special_q     <= 1'b0;
            special_exc_q <= 1'b0;
            special_res_q <= '0;
            exp_q         <= '0;
        end else if (en) begin
            if (load) begin
                count         <= '0;
                sign_q        <= in_sign;
                special_q     <= in_special;
                special_exc_q <= spec_exc;
                special_res_q <= spec_res;
                exp_q         <= $signed(exp_calc);
            end else if (step) begin
                count <= count + 5'd1;
            end
        end
    end

    mantissa_divider u_mantissa_divider (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .step     (step),
        .dividend ({1'b1, a[22:0]}),
        .divisor  ({1'b1, b[22:0]}),
        .quotient (quotient)
    );

    // Q lies in (2^23, 2^25): either already normalised at bit 24 or one place lower.
    assign exp_adj = quotient[Q_W-1] ? exp_q : exp_q - 10'sd1;
    assign mant    = quotient[Q_W-1] ? quotient[23:1] : quotient[22:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (en) begin
            done <= finish;
            if (finish) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                exception <= 1'b0;
                if (special_q) begin
                    result    <= special_res_q;
                    exception <= special_exc_q;
                end else if (exp_adj >= EXP_MAX_S) begin
                    result   <= {sign_q, 8'hFF, 23'h0};
                    overflow <= 1'b1;
                end else if (exp_adj <= 10'sd0) begin
                    result    <= {sign_q, 31'h0};
                    underflow <= 1'b1;
                end else begin
                    result <= {sign_q, exp_adj[7:0], mant};
                end
            end
        end
    end

endmodule

// File: doc/floating_divider_iterative.md
# floating_divider_iterative

Sequential IEEE-754 single-precision divider computing a / b with a radix-2 restoring mantissa iteration, one quotient bit per clock. It is the inverse-operation companion of the team's sequential floating-point multiplier and shares its operand/result/flag conventions, adding an explicit start/busy/done handshake. Rounding is truncation (toward zero); denormals are flushed to zero.

## Interface
- Parameters: none (format fixed at 32-bit single precision).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  clock enable; low freezes every register (including done)
- start  in  1  request; sampled only in IDLE with en=1
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle (one enabled cycle) completion pulse
- result  out  32  quotient, held until next completion
- overflow  out  1  result exponent ≥ 255; result = signed infinity
- underflow  out  1  result exponent ≤ 0; result = signed zero
- exception  out  1  divide-by-zero or invalid (NaN, 0/0, inf/inf)

## Operation
- States: IDLE, DIV, FIN.
- IDLE + start: capture a, b; sign = a[31]^b[31]; classify operands (exp=0 → zero, exp=255 & mant=0 → inf, exp=255 & mant≠0 → NaN); special → FIN, else → DIV with iteration count 0.
- Special results (exception as noted, overflow=underflow=0): any NaN, 0/0, inf/inf → 32'h7FC00000, exception=1; finite nonzero / 0 → {sign, 8'hFF, 23'h0}, exception=1; inf / finite → signed inf, exception=0; 0 / nonzero or finite / inf → signed zero, exception=0.
- DIV: mantissas ma={1,a[22:0]}, mb={1,b[22:0]} (24 bits); restoring iteration yields 25-bit Q = floor(ma·2^24 / mb), Q ∈ (2^23, 2^25); 25 iterations, partial remainder 25 bits, no sticky/round bits kept.
- Exponent: e = ea − eb + 127, 10-bit signed. FIN: if Q[24]=1, mant=Q[23:1]; else mant=Q[22:0], e−1.
- e ≥ 255 → {sign, 8'hFF, 23'h0}, overflow=1. e ≤ 0 → {sign, 31'h0}, underflow=1. Else {sign, e[7:0], mant}.
- FIN: register result and flags, pulse done, return to IDLE. Flags valid with done, held with result.
- start while busy: ignored. Operand changes after capture: no effect.

## Timing
- Reset (async assert, any state): state IDLE, busy=0, done=0, result=0, overflow=underflow=exception=0; in-flight operation discarded, no done produced.
- Normal path: start sampled at edge 0; DIV on edges 1–25; FIN on edge 26; done, result valid after edge 26 (26 cycles), busy high after edges 0–25.
- Special path: start at edge 0, FIN at edge 1; done after edge 1.
- en=0: no state, counter, or output change; latency extended by number of disabled cycles; an asserted done stays high until the next enabled edge.
- Back-to-back: start may be asserted in the cycle done is high (state IDLE); accepted at that edge.

## Structure
- Package fp_div_pkg: state enum (IDLE, DIV, FIN), EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=24, Q_W=25.
- Sub-module mantissa_divider: 24-bit restoring iterator (load, step, 25-bit Q out); top holds FSM, unpack/classify, exponent, pack.

## Test plan
- 0x40F00000 (7.5) / 0x40200000 (2.5) → result 0x40400000, flags 0, done exactly 26 cycles after start, busy high throughout.
- 0xC219C000 (−38.4375) / 0x40A40000 (5.125) → 0xC0F00000 (−7.5) (Q[24]=0 path); 0x3F800000 / 0x40400000 → 0x3EAAAAAA (truncation).
- 0x40A00000 / 0 → 0x7F800000, exception=1, done after 1 cycle; 0/0 → 0x7FC00000, exception=1; 0/0x40000000 → 0x00000000, flags 0.
- 0x7F000000 / 0x3E800000 → 0x7F800000, overflow=1; 0x00800000 / 0x40000000 → 0x00000000, underflow=1.
- en low 5 cycles during DIV → done at 31 cycles, result unchanged; start pulses while busy ignored.
- reset asserted at cycle 10 of DIV → immediately busy=0, outputs zero, no done; next start completes normally.
